aw_seq_tagger: RTL
==================

# aw_seq_tagger

Write-address sequence tagger for the AXI node write path. It accepts AW requests carrying a short master ID and stamps each one with a per-ID sequence number, forming the extended ID {seq, id}. It registers the request toward the slave side and counts outstanding writes per ID. It is the direct upstream partner of the per-ID B-response sequence checkers, which expect responses in exactly the order this block issues sequence numbers. Issue stalls per ID before a sequence number could alias.

## Interface
- ID_width, 2, width of the master ID; number of tracked IDs N = 2^ID_width
- seq_width, 4, width of the sequence field; at most 2^seq_width writes outstanding per ID
- ADDR_width, 32, AW address width
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- s_awid  input  ID_width  upstream master ID
- s_awaddr  input  ADDR_width  upstream write address
- s_awvalid  input  1  upstream request valid
- s_awready  output  1  upstream request accepted
- m_awid  output  ID_width+seq_width  tagged ID {seq, id}; id in [ID_width-1:0], seq in [ID_width+seq_width-1:ID_width]
- m_awaddr  output  ADDR_width  registered address
- m_awvalid  output  1  downstream request valid
- m_awready  input  1  downstream ready
- b_retire  input  N  bit k high = one write of ID k retired this cycle (B checker match AND BREADY); more than one bit may be high
- idle  output  1  no writes outstanding on any ID and the output register is empty
- err_underflow  output  1  sticky; b_retire seen for an ID with zero outstanding

## Operation
- Per ID k:
  - issue_seq[k], seq_width bits; next sequence number to stamp.
  - outst[k], seq_width+1 bits, range 0..2^seq_width.
  - full[k] = (outst[k] == 2^seq_width).
- Output stage is a single register holding m_awvalid, m_awid and m_awaddr.
  - slot_free = !m_awvalid || m_awready.
  - s_awready = slot_free && !full[s_awid]. Combinational; may depend on s_awid but never on s_awvalid.
- Accept = s_awvalid && s_awready. On accept:
  - m_awid <= {issue_seq[s_awid], s_awid}.
  - m_awaddr <= s_awaddr.
  - m_awvalid <= 1.
  - issue_seq[s_awid] increments, wrapping modulo 2^seq_width.
  - outst[s_awid] increments.
- When m_awvalid && m_awready without a new accept, m_awvalid <= 0.
- While m_awvalid && !m_awready, the outputs hold stable. This follows the AXI rule that valid must not drop and payload must not change until the handshake completes.
- For each k with b_retire[k] = 1:
  - if outst[k] > 0, outst[k] decrements;
  - else outst[k] is unchanged and err_underflow <= 1.
- Accept and retire on the same ID in the same cycle leave outst unchanged; issue_seq still increments.
- Sequence numbers are issued strictly in order per ID, so the seq of the n-th accepted write of ID k is (n-1) mod 2^seq_width.
- idle = !m_awvalid && (all outst[k] == 0). Combinational from registers.

## Timing
- Reset values:
  - m_awvalid = 0, m_awid = 0, m_awaddr = 0.
  - All issue_seq = 0, all outst = 0.
  - err_underflow = 0, idle = 1.
  - s_awready = 1.
- Latency: request accepted at edge T appears on m_aw* in the cycle after T.
- Throughput: one request per cycle while m_awready = 1 and the ID is not full. s_awready depends combinationally on m_awready (pass-through ready).
- Full boundary:
  - With outst[k] = 2^seq_width, s_awready = 0 while s_awid = k.
  - Another ID may still be accepted.
  - A same-cycle b_retire[k] does not unblock that cycle; the request is accepted in the following cycle.
- Wrap: issue_seq 2^seq_width-1 -> 0. Full-stall guarantees no two outstanding writes of one ID share a seq.
- Reset mid-operation: reset asserted at any time clears every register immediately, including a pending m_awvalid. The output payload is discarded.

## Test plan
- Reset, then 3 writes of ID 1 with m_awready=1 -> m_awid = 0x01, 0x05, 0x09 on consecutive cycles, each one cycle after accept; idle=0.
- ID 2, 16 accepts with no retire -> 17th request sees s_awready=0; s_awid=0 in that cycle is accepted with m_awid=0x00; then b_retire[2] pulse -> next cycle ID-2 request accepted with m_awid=0x02 (seq wrapped to 0).
- m_awready=0 for 4 cycles with m_awvalid=1 -> m_awid/m_awaddr held stable, s_awready=0; m_awready=1 -> transfer, and a new request is accepted in the same cycle.
- Accept ID 3 together with b_retire[3] while outst[3]=5 -> outst[3] stays 5, issue_seq[3] advances by 1; b_retire=4'b1001 with outst[0]=1, outst[3]=1 -> both go to 0, idle=1 once the register is empty.
- b_retire[1] with outst[1]=0 -> err_underflow=1 and stays high; outst[1] stays 0.
- Assert reset_n=0 while m_awvalid=1 and outst nonzero -> m_awvalid=0, idle=1, first write after release gets seq 0.

Source files
------------

// File: rtl/aw_seq_tagger.sv
// Write-address sequence tagger: stamps each AW request with a per-ID sequence
// number, registers it toward the slave and tracks outstanding writes per ID.
module aw_seq_tagger #(
  parameter int ID_width   = 2,
  parameter int seq_width  = 4,
  parameter int ADDR_width = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ID_width-1:0]           s_awid,
  input  logic [ADDR_width-1:0]         s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  output logic [ID_width+seq_width-1:0] m_awid,
  output logic [ADDR_width-1:0]         m_awaddr,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  input  logic [(1<<ID_width)-1:0]      b_retire,
  output logic                          idle,
  output logic                          err_underflow
);

  localparam int N = 1 << ID_width;
  localparam logic [seq_width:0] OutstFull = {1'b1, {seq_width{1'b0}}};

  logic [seq_width-1:0]          issueSeq_q [N];
  logic [seq_width-1:0]          issueSeq_d [N];
  logic [seq_width:0]            outst_q    [N];
  logic [seq_width:0]            outst_d    [N];
  logic                          awValid_q, awValid_d;
  logic [ID_width+seq_width-1:0] awId_q, awId_d;
  logic [ADDR_width-1:0]         awAddr_q, awAddr_d;
  logic                          errUnderflow_q, errUnderflow_d;
  logic                          slotFree;
  logic                          accept;
  logic                          anyOutst;

  // An ID at full outstanding count is held off so its sequence numbers never alias.
  assign slotFree  = !awValid_q || m_awready;
  assign s_awready = slotFree && (outst_q[s_awid] != OutstFull);
  assign accept    = s_awvalid && s_awready;

  always_comb begin
    awValid_d      = awValid_q;
    awId_d         = awId_q;
    awAddr_d       = awAddr_q;
    errUnderflow_d = errUnderflow_q;
    anyOutst       = 1'b0;

    if (accept) begin
      awValid_d = 1'b1;
      awId_d    = {issueSeq_q[s_awid], s_awid};
      awAddr_d  = s_awaddr;
    end else if (m_awready) begin
      awValid_d = 1'b0;
    end

    for (int k = 0; k < N; k++) begin
      issueSeq_d[k] = issueSeq_q[k];
      outst_d[k]    = outst_q[k];
      // A retire only counts against a nonzero count; a simultaneous accept cancels it out.
      if (accept && (s_awid == ID_width'(k))) begin
        issueSeq_d[k] = issueSeq_q[k] + seq_width'(1);
        if (!(b_retire[k] && (outst_q[k] != '0))) begin
          outst_d[k] = outst_q[k] + (seq_width+1)'(1);
        end
      end else if (b_retire[k] && (outst_q[k] != '0)) begin
        outst_d[k] = outst_q[k] - (seq_width+1)'(1);
      end
      if (b_retire[k] && (outst_q[k] == '0)) begin
        errUnderflow_d = 1'b1;
      end
      if (outst_q[k] != '0) begin
        anyOutst = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      awValid_q      <= 1'b0;
      awId_q         <= '0;
      awAddr_q       <= '0;
      errUnderflow_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        issueSeq_q[k] <= '0;
        outst_q[k]    <= '0;
      end
    end else begin
      awValid_q      <= awValid_d;
      awId_q         <= awId_d;
      awAddr_q       <= awAddr_d;
      errUnderflow_q <= errUnderflow_d;
      for (int k = 0; k < N; k++) begin
        issueSeq_q[k] <= issueSeq_d[k];
        outst_q[k]    <= outst_d[k];
      end
    end
  end

  assign m_awvalid     = awValid_q;
  assign m_awid        = awId_q;
  assign m_awaddr      = awAddr_q;
  assign err_underflow = errUnderflow_q;
  assign idle          = !awValid_q && !anyOutst;

endmodule
